// File: rtl/histogram_frame_sequencer.sv
// Ping-pong gray histogram frame sequencer: clear, arm, accumulate, cumulative sweep, publish; HIST_MAX_TRACK_EN enables peak-bin tracking.
// Latency: bin written 1 cycle after its pixel; results published about 260 cycles after iFval falls.
// Backpressure: none; every valid pixel in ACCUM is taken, frames starting outside ARM are dropped with oSkip.
module histogram_frame_sequencer #(
    parameter int CNT_W      = 20,
    parameter int THRESH_PCT = 50
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iFval,
    input  logic [7:0]       iGray,
    input  logic             iGrayValid,
    output logic [8:0]       oHistAddr,
    output logic             oHistWe,
    output logic [CNT_W-1:0] oHistWdata,
    input  logic [CNT_W-1:0] iHistRdata,
    output logic [7:0]       oCumAddr,
    output logic             oCumWe,
    output logic [CNT_W-1:0] oCumWdata,
    output logic             oBank,
    output logic [7:0]       oThresh,
    output logic [CNT_W-1:0] oMaxValue,
    output logic             oDone,
    output logic             oSkip
);

    typedef enum logic [2:0] {S_CLEAR, S_ARM, S_ACCUM, S_DRAIN, S_CUMSUM, S_PUBLISH} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_CLR, OP_INC, OP_CUM} op_t;

    localparam int CMP_W = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_d;
    op_t              s1_op, s1_op_d;
    logic [7:0]       s1_bin, s1_bin_d, rd_bin;
    logic [8:0]       cnt, cnt_d;
    logic             fval_q, fval_rise, fval_fall, pix_take;
    logic [CNT_W-1:0] total, acc, acc_next, inc_src, last_wdata;
    logic [CNT_W:0]   acc_sum;
    logic             last_vld, found, hit;
    logic [7:0]       last_bin, thr_stage;
    logic [CMP_W-1:0] lhs, rhs;

    assign fval_rise = iFval & ~fval_q;
    assign fval_fall = ~iFval & fval_q;
    assign pix_take  = (state == S_ACCUM) & iFval & iGrayValid;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        s1_op_d  = OP_NONE;
        s1_bin_d = s1_bin;
        rd_bin   = cnt[7:0];
        case (state)
            S_CLEAR: begin
                s1_op_d  = OP_CLR;
                s1_bin_d = cnt[7:0];
                cnt_d    = cnt + 9'd1;
                if (cnt[7:0] == 8'hFF) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end
            end
            S_ARM: if (fval_rise) state_d = S_ACCUM;
            S_ACCUM: begin
                rd_bin = iGray;
                if (fval_fall) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (pix_take) begin
                    s1_op_d  = OP_INC;
                    s1_bin_d = iGray;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt + 9'd1;
                if (cnt[0]) begin
                    state_d = S_CUMSUM;
                    cnt_d   = '0;
                end
            end
            S_CUMSUM: begin
                if (!cnt[8]) begin
                    s1_op_d  = OP_CUM;
                    s1_bin_d = cnt[7:0];
                    cnt_d    = cnt + 9'd1;
                end
                if (s1_op == OP_CUM && s1_bin == 8'hFF) state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // The RAM registers oHistAddr; both iHistRdata and a write strobed by oHistWe
    // refer to the address presented in the previous cycle.
    assign inc_src    = (last_vld && last_bin == s1_bin) ? last_wdata : iHistRdata;
    assign oHistAddr  = {oBank, rd_bin};
    assign oHistWe    = (s1_op == OP_CLR) || (s1_op == OP_INC);
    assign oHistWdata = (s1_op != OP_INC) ? '0 :
                        (inc_src == CNT_MAX) ? inc_src : inc_src + CNT_W'(1);

    assign acc_sum   = {1'b0, acc} + {1'b0, iHistRdata};
    assign acc_next  = acc_sum[CNT_W] ? CNT_MAX : acc_sum[CNT_W-1:0];
    assign lhs       = CMP_W'(acc_next) * CMP_W'(100);
    assign rhs       = CMP_W'(total) * CMP_W'(THRESH_PCT);
    assign hit       = lhs >= rhs;
    assign oCumAddr  = s1_bin;
    assign oCumWe    = (s1_op == OP_CUM);
    assign oCumWdata = acc_next;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= S_CLEAR;
            cnt        <= '0;
            s1_op      <= OP_NONE;
            s1_bin     <= '0;
            fval_q     <= 1'b0;
            total      <= '0;
            acc        <= '0;
            last_vld   <= 1'b0;
            last_bin   <= '0;
            last_wdata <= '0;
            found      <= 1'b0;
            thr_stage  <= 8'hFF;
            oBank      <= 1'b0;
            oThresh    <= 8'd128;
            oDone      <= 1'b0;
            oSkip      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            s1_op      <= s1_op_d;
            s1_bin     <= s1_bin_d;
            fval_q     <= iFval;
            oSkip      <= fval_rise && (state != S_ARM);
            oDone      <= (state == S_PUBLISH);
            last_vld   <= (s1_op == OP_INC);
            last_bin   <= s1_bin;
            last_wdata <= oHistWdata;
            if (state == S_ARM && fval_rise)
                total <= '0;
            else if (pix_take && total != CNT_MAX)
                total <= total + CNT_W'(1);
            if (state == S_DRAIN) begin
                acc       <= '0;
                found     <= 1'b0;
                thr_stage <= 8'hFF;
            end else if (s1_op == OP_CUM) begin
                acc <= acc_next;
                if (!found && hit) begin
                    found     <= 1'b1;
                    thr_stage <= s1_bin;
                end
            end
            if (state == S_PUBLISH) begin
                oThresh <= (total == '0) ? 8'd0 : thr_stage;
                oBank   <= ~oBank;
            end
        end
    end

`ifdef HIST_MAX_TRACK_EN
    logic [CNT_W-1:0] max_stage, max_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            max_stage <= '0;
            max_q     <= '0;
        end else begin
            if (state == S_DRAIN)
                max_stage <= '0;
            else if (s1_op == OP_CUM && iHistRdata > max_stage)
                max_stage <= iHistRdata;
            if (state == S_PUBLISH) max_q <= max_stage;
        end
    end

    assign oMaxValue = max_q;
`else
    // Without tracking, displayers always scale to the full count range.
    assign oMaxValue = CNT_MAX;
`endif

endmodule
